// File: rtl/match_controller.sv
// Match-level sequencer: attract -> countdown -> play -> game-over, paced by frame_tick.
// Define MATCH_TIMER_EN to add the match clock (timer_sec countdown and time-out winner).
module match_controller #(
  parameter int FRAMES_PER_SEC       = 60,
  parameter int COUNT_STEP_FRAMES    = 60,
  parameter int MATCH_SECONDS        = 180,
  parameter int GAMEOVER_HOLD_FRAMES = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       start1,
  input  logic       start2,
  input  logic [1:0] stocks1,
  input  logic [1:0] stocks2,
  output logic [2:0] match_state,
  output logic [1:0] countdown_val,
  output logic [7:0] timer_sec,
  output logic       inputs_enable,
  output logic       game_reset,
  output logic [1:0] winner
);

  localparam int MAX_A = (FRAMES_PER_SEC > COUNT_STEP_FRAMES) ? FRAMES_PER_SEC : COUNT_STEP_FRAMES;
  localparam int MAX_B = (MATCH_SECONDS > GAMEOVER_HOLD_FRAMES) ? MATCH_SECONDS : GAMEOVER_HOLD_FRAMES;
  localparam int MAXP  = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int CW    = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    ST_ATTRACT   = 3'd0,
    ST_COUNTDOWN = 3'd1,
    ST_PLAYING   = 3'd2,
    ST_PAUSED    = 3'd3,
    ST_GAME_OVER = 3'd4
  } state_t;

  state_t          state_q;
  logic [1:0]      countdown_q;
  logic            inputs_en_q;
  logic            game_reset_q;
  logic [1:0]      winner_q;
  logic [CW-1:0]   step_cnt_q;
  logic [CW-1:0]   hold_cnt_q;
  logic            start_prev_q;

  logic            start_any;
  logic            press;
  logic            step_wrap;
  logic            cd_done;
  logic [1:0]      stock_win;
  logic            timer_expire;
  logic [1:0]      time_win;

  // Edge detect on the frame-sampled start level; a held button yields one press.
  assign start_any = start1 | start2;
  assign press     = frame_tick & start_any & ~start_prev_q;
  assign step_wrap = frame_tick && (step_cnt_q == CW'(COUNT_STEP_FRAMES - 1));
  assign cd_done   = (state_q == ST_COUNTDOWN) && step_wrap && (countdown_q == 2'd1);

  always_comb begin
    stock_win = 2'd0;
    if (stocks1 == 2'd0 && stocks2 == 2'd0) stock_win = 2'd3;
    else if (stocks1 == 2'd0)               stock_win = 2'd2;
    else if (stocks2 == 2'd0)               stock_win = 2'd1;
  end

`ifdef MATCH_TIMER_EN
  logic [CW-1:0] sec_cnt_q;
  logic [7:0]    timer_q;
  logic          sec_wrap;

  assign sec_wrap     = frame_tick && (sec_cnt_q == CW'(FRAMES_PER_SEC - 1));
  assign timer_expire = sec_wrap && (timer_q == 8'd1);
  assign timer_sec    = timer_q;

  always_comb begin
    time_win = 2'd3;
    if (stocks1 > stocks2)      time_win = 2'd1;
    else if (stocks2 > stocks1) time_win = 2'd2;
  end

  // The clock only runs in PLAYING; PAUSED and every other state freeze it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sec_cnt_q <= '0;
      timer_q   <= 8'd0;
    end else if (cd_done) begin
      sec_cnt_q <= '0;
      timer_q   <= 8'(MATCH_SECONDS);
    end else if (state_q == ST_PLAYING && frame_tick) begin
      if (sec_wrap) begin
        sec_cnt_q <= '0;
        if (timer_q != 8'd0) timer_q <= timer_q - 8'd1;
      end else begin
        sec_cnt_q <= sec_cnt_q + CW'(1);
      end
    end
  end
`else
  assign timer_expire = 1'b0;
  assign time_win     = 2'd0;
  assign timer_sec    = 8'd0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_ATTRACT;
      countdown_q  <= 2'd0;
      inputs_en_q  <= 1'b0;
      game_reset_q <= 1'b0;
      winner_q     <= 2'd0;
      step_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      start_prev_q <= 1'b0;
    end else begin
      game_reset_q <= 1'b0;
      if (frame_tick) start_prev_q <= start_any;
      case (state_q)
        ST_ATTRACT: begin
          if (press) begin
            state_q      <= ST_COUNTDOWN;
            game_reset_q <= 1'b1;
            winner_q     <= 2'd0;
            countdown_q  <= 2'd3;
            step_cnt_q   <= '0;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_tick) begin
            if (step_wrap) begin
              step_cnt_q <= '0;
              if (countdown_q == 2'd1) begin
                state_q     <= ST_PLAYING;
                countdown_q <= 2'd0;
                inputs_en_q <= 1'b1;
              end else begin
                countdown_q <= countdown_q - 2'd1;
              end
            end else begin
              step_cnt_q <= step_cnt_q + CW'(1);
            end
          end
        end
        ST_PLAYING: begin
          // Stock-out beats time-out beats pause.
          if (stock_win != 2'd0) begin
            state_q     <= ST_GAME_OVER;
            winner_q    <= stock_win;
            inputs_en_q <= 1'b0;
            hold_cnt_q  <= '0;
          end else if (timer_expire) begin
            state_q     <= ST_GAME_OVER;
            winner_q    <= time_win;
            inputs_en_q <= 1'b0;
            hold_cnt_q  <= '0;
          end else if (press) begin
            state_q     <= ST_PAUSED;
            inputs_en_q <= 1'b0;
          end
        end
        ST_PAUSED: begin
          if (press) begin
            state_q     <= ST_PLAYING;
            inputs_en_q <= 1'b1;
          end
        end
        ST_GAME_OVER: begin
          if (frame_tick) begin
            if (hold_cnt_q == CW'(GAMEOVER_HOLD_FRAMES - 1)) begin
              state_q    <= ST_ATTRACT;
              hold_cnt_q <= '0;
            end else begin
              hold_cnt_q <= hold_cnt_q + CW'(1);
            end
          end
        end
        default: begin
          state_q     <= ST_ATTRACT;
          inputs_en_q <= 1'b0;
        end
      endcase
    end
  end

  assign match_state   = state_q;
  assign countdown_val = countdown_q;
  assign inputs_enable = inputs_en_q;
  assign game_reset    = game_reset_q;
  assign winner        = winner_q;

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: expected output snapshots, stamped with the frame count at
// which they must appear, are queued by the stimulus and popped by a change-driven monitor.
module tb_match_controller;

  localparam int W = 33;
  localparam logic [2:0] S_ATT = 3'd0, S_CD = 3'd1, S_PLAY = 3'd2, S_PAUSE = 3'd3, S_GO = 3'd4;

  logic       clk = 1'b0;
  logic       reset_n, frame_tick, start1, start2;
  logic [1:0] stocks1, stocks2;
  logic [2:0] match_state;
  logic [1:0] countdown_val;
  logic [7:0] timer_sec;
  logic       inputs_enable, game_reset;
  logic [1:0] winner;

  logic [W-1:0] exp_q[$];
  int           checks = 0;
  int           passes = 0;
  int           tick_cnt = 0;
  logic [16:0]  cur_out, prev_out;
  logic         have_prev = 1'b0;

  always #5 clk = ~clk;

  match_controller #(
    .FRAMES_PER_SEC(4), .COUNT_STEP_FRAMES(4), .MATCH_SECONDS(3), .GAMEOVER_HOLD_FRAMES(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick),
    .start1(start1), .start2(start2), .stocks1(stocks1), .stocks2(stocks2),
    .match_state(match_state), .countdown_val(countdown_val), .timer_sec(timer_sec),
    .inputs_enable(inputs_enable), .game_reset(game_reset), .winner(winner)
  );

  assign cur_out = {match_state, countdown_val, timer_sec, inputs_enable, game_reset, winner};

  function automatic logic [7:0] tv(input logic [7:0] x);
`ifdef MATCH_TIMER_EN
    return x;
`else
    return 8'd0 & x;
`endif
  endfunction

  task automatic exp_push(input int dt, input logic [2:0] st, input logic [1:0] cd,
                          input logic [7:0] tm, input logic ie, input logic gr,
                          input logic [1:0] win);
    exp_q.push_back({16'(tick_cnt + dt), st, cd, tm, ie, gr, win});
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    tick_cnt++;
    idle(1);
    frame_tick = 1'b0;
    idle(2);
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) $display("FAIL %s: got %0d, expected %0d", name, act, req);
    else passes++;
  endtask

  // Monitor: every visible change of the output tuple consumes one expectation.
  always @(negedge clk) begin
    logic [W-1:0] got, exp;
    if (!have_prev || cur_out !== prev_out) begin
      checks++;
      got = {16'(tick_cnt), cur_out};
      if (exp_q.size() == 0) begin
        $display("FAIL scoreboard unexpected change: got tick=%0d st=%0d cd=%0d tm=%0d ie=%0b gr=%0b win=%0d, expected none",
                 got[32:17], got[16:14], got[13:12], got[11:4], got[3], got[2], got[1:0]);
      end else begin
        exp = exp_q.pop_front();
        if (got !== exp)
          $display("FAIL scoreboard: got tick=%0d st=%0d cd=%0d tm=%0d ie=%0b gr=%0b win=%0d, expected tick=%0d st=%0d cd=%0d tm=%0d ie=%0b gr=%0b win=%0d",
                   got[32:17], got[16:14], got[13:12], got[11:4], got[3], got[2], got[1:0],
                   exp[32:17], exp[16:14], exp[13:12], exp[11:4], exp[3], exp[2], exp[1:0]);
        else passes++;
      end
      prev_out  = cur_out;
      have_prev = 1'b1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b1; frame_tick = 1'b0; start1 = 1'b0; start2 = 1'b0;
    stocks1 = 2'd3; stocks2 = 2'd3;
    exp_push(0, S_ATT, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);
    #2 reset_n = 1'b0;
    repeat (3) @(negedge clk);
    #1 reset_n = 1'b1;
    idle(2);

    // Held start -> one press, countdown 3,2,1 at 4 ticks each, then play.
    exp_push(1,  S_CD,   2'd3, 8'd0,      1'b0, 1'b1, 2'd0);
    exp_push(1,  S_CD,   2'd3, 8'd0,      1'b0, 1'b0, 2'd0);
    exp_push(5,  S_CD,   2'd2, 8'd0,      1'b0, 1'b0, 2'd0);
    exp_push(9,  S_CD,   2'd1, 8'd0,      1'b0, 1'b0, 2'd0);
    exp_push(13, S_PLAY, 2'd0, tv(8'd3),  1'b1, 1'b0, 2'd0);
    start1 = 1'b1; ticks(3); start1 = 1'b0; ticks(10);

    // P2 stock-out between ticks; presses ignored in game-over; winner held in attract.
    exp_push(2,  S_GO,   2'd0, tv(8'd3),  1'b0, 1'b0, 2'd1);
    exp_push(10, S_ATT,  2'd0, tv(8'd3),  1'b0, 1'b0, 2'd1);
    ticks(2); stocks2 = 2'd0; idle(1); stocks2 = 2'd3;
    start2 = 1'b1; ticks(2); start2 = 1'b0; ticks(6);

    // Pause/resume with stocks ignored while paused, then start press racing a stock-out.
    exp_push(1,  S_CD,    2'd3, tv(8'd3), 1'b0, 1'b1, 2'd0);
    exp_push(1,  S_CD,    2'd3, tv(8'd3), 1'b0, 1'b0, 2'd0);
    exp_push(5,  S_CD,    2'd2, tv(8'd3), 1'b0, 1'b0, 2'd0);
    exp_push(9,  S_CD,    2'd1, tv(8'd3), 1'b0, 1'b0, 2'd0);
    exp_push(13, S_PLAY,  2'd0, tv(8'd3), 1'b1, 1'b0, 2'd0);
    exp_push(16, S_PAUSE, 2'd0, tv(8'd3), 1'b0, 1'b0, 2'd0);
    exp_push(27, S_PLAY,  2'd0, tv(8'd3), 1'b1, 1'b0, 2'd0);
`ifdef MATCH_TIMER_EN
    exp_push(28, S_PLAY,  2'd0, 8'd2,     1'b1, 1'b0, 2'd0);
`endif
    exp_push(29, S_GO,    2'd0, tv(8'd2), 1'b0, 1'b0, 2'd2);
    exp_push(37, S_ATT,   2'd0, tv(8'd2), 1'b0, 1'b0, 2'd2);
    start1 = 1'b1; tick(); start1 = 1'b0; ticks(12);
    ticks(2);
    start2 = 1'b1; tick(); start2 = 1'b0;
    ticks(2); stocks2 = 2'd0; ticks(4); stocks2 = 2'd3; ticks(4);
    start1 = 1'b1; tick(); start1 = 1'b0;
    tick();
    stocks1 = 2'd0; start2 = 1'b1; tick(); start2 = 1'b0; stocks1 = 2'd3;
    ticks(8);

`ifdef MATCH_TIMER_EN
    // Time-out: more stocks wins, then equal stocks draw.
    stocks1 = 2'd2; stocks2 = 2'd1;
    exp_push(1,  S_CD,   2'd3, 8'd2, 1'b0, 1'b1, 2'd0);
    exp_push(1,  S_CD,   2'd3, 8'd2, 1'b0, 1'b0, 2'd0);
    exp_push(5,  S_CD,   2'd2, 8'd2, 1'b0, 1'b0, 2'd0);
    exp_push(9,  S_CD,   2'd1, 8'd2, 1'b0, 1'b0, 2'd0);
    exp_push(13, S_PLAY, 2'd0, 8'd3, 1'b1, 1'b0, 2'd0);
    exp_push(17, S_PLAY, 2'd0, 8'd2, 1'b1, 1'b0, 2'd0);
    exp_push(21, S_PLAY, 2'd0, 8'd1, 1'b1, 1'b0, 2'd0);
    exp_push(25, S_GO,   2'd0, 8'd0, 1'b0, 1'b0, 2'd1);
    exp_push(33, S_ATT,  2'd0, 8'd0, 1'b0, 1'b0, 2'd1);
    start1 = 1'b1; tick(); start1 = 1'b0; ticks(32);

    stocks2 = 2'd2;
    exp_push(1,  S_CD,   2'd3, 8'd0, 1'b0, 1'b1, 2'd0);
    exp_push(1,  S_CD,   2'd3, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(5,  S_CD,   2'd2, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(9,  S_CD,   2'd1, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(13, S_PLAY, 2'd0, 8'd3, 1'b1, 1'b0, 2'd0);
    exp_push(17, S_PLAY, 2'd0, 8'd2, 1'b1, 1'b0, 2'd0);
    exp_push(21, S_PLAY, 2'd0, 8'd1, 1'b1, 1'b0, 2'd0);
    exp_push(25, S_GO,   2'd0, 8'd0, 1'b0, 1'b0, 2'd3);
    exp_push(33, S_ATT,  2'd0, 8'd0, 1'b0, 1'b0, 2'd3);
    start2 = 1'b1; tick(); start2 = 1'b0; ticks(32);

    // Double stock-out on the final timer tick: stock rule draw, not time-out P1 win.
    stocks1 = 2'd2; stocks2 = 2'd1;
    exp_push(1,  S_CD,   2'd3, 8'd0, 1'b0, 1'b1, 2'd0);
    exp_push(1,  S_CD,   2'd3, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(5,  S_CD,   2'd2, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(9,  S_CD,   2'd1, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(13, S_PLAY, 2'd0, 8'd3, 1'b1, 1'b0, 2'd0);
    exp_push(17, S_PLAY, 2'd0, 8'd2, 1'b1, 1'b0, 2'd0);
    exp_push(21, S_PLAY, 2'd0, 8'd1, 1'b1, 1'b0, 2'd0);
    exp_push(25, S_GO,   2'd0, 8'd0, 1'b0, 1'b0, 2'd3);
    exp_push(33, S_ATT,  2'd0, 8'd0, 1'b0, 1'b0, 2'd3);
    start1 = 1'b1; tick(); start1 = 1'b0; ticks(23);
    stocks1 = 2'd0; stocks2 = 2'd0; tick(); stocks1 = 2'd3; stocks2 = 2'd3;
    ticks(8);
`endif

    // Asynchronous reset mid-countdown: immediate reset values, no game_reset pulse.
    exp_push(1, S_CD,  2'd3, 8'd0, 1'b0, 1'b1, 2'd0);
    exp_push(1, S_CD,  2'd3, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(5, S_CD,  2'd2, 8'd0, 1'b0, 1'b0, 2'd0);
    exp_push(6, S_ATT, 2'd0, 8'd0, 1'b0, 1'b0, 2'd0);
    start1 = 1'b1; tick(); start1 = 1'b0; ticks(5);
    reset_n = 1'b0;
    #1;
    check("async_reset_state", 32'(match_state), 32'd0);
    check("async_reset_countdown", 32'(countdown_val), 32'd0);
    check("async_reset_game_reset", 32'(game_reset), 32'd0);
    check("async_reset_winner", 32'(winner), 32'd0);
    idle(1);
    start1 = 1'b1; ticks(2); start1 = 1'b0;
    reset_n = 1'b1;
    idle(2);
    tick();
    idle(3);

    checks++;
    if (exp_q.size() != 0) $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
    else passes++;

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
